// File: rtl/shift_lag_line.sv
// Tapped delay line: delivers x[n-k] for a one-hot lag k beside each sample.
// Ports: clk, rst, in_valid, din, tap -> dout, out_valid, sample_idx, frame_end, tap_err.
module shift_lag_line #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 10,
    parameter int FRAME_LEN = 160,
    parameter int IDX_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din,
    input  logic [DEPTH:0]    tap,
    output logic [DATA_W-1:0] dout,
    output logic              out_valid,
    output logic [IDX_W-1:0]  sample_idx,
    output logic              frame_end,
    output logic              tap_err
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    generate
        if (DEPTH >= FRAME_LEN) begin : g_bad_depth
            $error("shift_lag_line: DEPTH must be below FRAME_LEN");
        end
        if ((64'd1 << IDX_W) < 64'(FRAME_LEN)) begin : g_bad_idx
            $error("shift_lag_line: IDX_W too narrow for FRAME_LEN");
        end
    endgenerate

    logic [DATA_W-1:0] h [1:DEPTH];
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] sel;
    logic              tap_ok;
    logic              last;

    assign tap_ok = $onehot(tap);
    assign last   = (cnt == LAST);

    // OR-mux; only meaningful when tap is one-hot, otherwise masked to 0.
    always_comb begin
        sel = '0;
        if (tap[0]) sel = din;
        for (int k = 1; k <= DEPTH; k++) begin
            if (tap[k]) sel = sel | h[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) h[k] <= '0;
            cnt        <= '0;
            dout       <= '0;
            out_valid  <= 1'b0;
            sample_idx <= '0;
            frame_end  <= 1'b0;
            tap_err    <= 1'b0;
        end else if (in_valid) begin
            dout       <= tap_ok ? sel : '0;
            out_valid  <= 1'b1;
            sample_idx <= cnt;
            frame_end  <= last;
            tap_err    <= ~tap_ok;
            // Clearing history at the boundary keeps lags inside one frame.
            if (last) begin
                for (int k = 1; k <= DEPTH; k++) h[k] <= '0;
                cnt <= '0;
            end else begin
                h[1] <= din;
                for (int k = 2; k <= DEPTH; k++) h[k] <= h[k-1];
                cnt <= cnt + 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
            frame_end <= 1'b0;
            tap_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_lag_line.sv
// Scoreboard bench for shift_lag_line: driver pushes expectations, monitor pops.
// Ports exercised: all, with default parameters.
module tb_shift_lag_line;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  i;
        logic        fe;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] din = '0;
    logic [10:0] tap = 11'd1;
    logic [15:0] dout;
    logic        out_valid;
    logic [7:0]  sample_idx;
    logic        frame_end;
    logic        tap_err;

    logic        rst_chk = 1'b0;
    logic        done = 1'b0;
    int          checks = 0;
    int          errors = 0;

    exp_t        q[$];
    int          mcnt = 0;
    logic [15:0] fr [0:159];
    logic [15:0] last_dout = '0;
    logic [7:0]  last_idx = '0;

    shift_lag_line dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .din(din),
        .tap(tap),
        .dout(dout),
        .out_valid(out_valid),
        .sample_idx(sample_idx),
        .frame_end(frame_end),
        .tap_err(tap_err)
    );

    always #5 clk = ~clk;

    // Model: keep the current frame's samples and look back k entries.
    task automatic send(input logic [15:0] d, input logic [10:0] t);
        exp_t e;
        int   n;
        int   k;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        din = d;
        tap = t;
        n = mcnt;
        fr[n] = d;
        e.i = 8'(n);
        e.fe = (n == 159);
        if ($countones(t) != 1) begin
            e.d = '0;
            e.err = 1'b1;
        end else begin
            k = 0;
            for (int b = 0; b < 11; b++) if (t[b]) k = b;
            e.err = 1'b0;
            if (k == 0) e.d = d;
            else if (n >= k) e.d = fr[n-k];
            else e.d = '0;
        end
        q.push_back(e);
        mcnt = (n == 159) ? 0 : n + 1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk or posedge rst_chk);
            if (rst_chk) begin
                checks++;
                if (dout !== 16'd0 || out_valid !== 1'b0 ||
                    sample_idx !== 8'd0 || frame_end !== 1'b0 ||
                    tap_err !== 1'b0 || q.size() != 0) begin
                    errors++;
                    $display("FAIL reset: dout=%0d ov=%0b idx=%0d fe=%0b err=%0b pend=%0d, want all 0",
                             dout, out_valid, sample_idx, frame_end, tap_err, q.size());
                end
                last_dout = '0;
                last_idx = '0;
            end else if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output: dout=%0d idx=%0d, want no output", dout, sample_idx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (dout !== e.d || sample_idx !== e.i ||
                        frame_end !== e.fe || tap_err !== e.err) begin
                        errors++;
                        $display("FAIL out: dout=%0d idx=%0d fe=%0b err=%0b, want dout=%0d idx=%0d fe=%0b err=%0b",
                                 dout, sample_idx, frame_end, tap_err, e.d, e.i, e.fe, e.err);
                    end
                    last_dout = e.d;
                    last_idx = e.i;
                end
            end else begin
                checks++;
                if (dout !== last_dout || sample_idx !== last_idx ||
                    frame_end !== 1'b0 || tap_err !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_hold: dout=%0d idx=%0d fe=%0b err=%0b, want dout=%0d idx=%0d fe=0 err=0",
                             dout, sample_idx, frame_end, tap_err, last_dout, last_idx);
                end
            end
            if (done && !rst_chk) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_outputs: pending=%0d, want 0", q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_chk = 1'b1;
        #1 rst_chk = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;

        // Lag 0 ramp, one frame.
        for (int n = 0; n < 160; n++) send(16'(n), 11'd1);
        // Lag 3 across two frames.
        for (int n = 0; n < 320; n++) send(16'((n % 160) + 1), 11'd1 << 3);
        // Maximum lag.
        for (int n = 0; n < 160; n++) send(16'(n + 100), 11'd1 << 10);
        // Lag 3 again with gaps between samples.
        for (int n = 0; n < 320; n++) begin
            send(16'((n % 160) + 1), 11'd1 << 3);
            idle();
        end
        // Illegal taps at idx 20 and 21.
        for (int n = 0; n < 160; n++) begin
            if (n == 20) send(16'(n * 5 + 3), 11'd0);
            else if (n == 21) send(16'(n * 5 + 3), 11'b00000000011);
            else send(16'(n * 5 + 3), 11'd1 << 1);
        end
        // Tap change between idx 50 and 51.
        for (int n = 0; n < 160; n++) begin
            if (n <= 50) send(16'(n * 3 + 7), 11'd1 << 1);
            else send(16'(n * 3 + 7), 11'd1 << 5);
        end
        // Mid-frame asynchronous reset.
        for (int n = 0; n < 80; n++) send(16'(n + 500), 11'd1 << 2);
        idle();
        #6 rst = 1'b1;
        mcnt = 0;
        #1 rst_chk = 1'b1;
        #1 rst_chk = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        for (int n = 0; n < 5; n++) send(16'(n + 900), 11'd1 << 2);
        idle();
        idle();
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1, "timeout");
    end

endmodule
